// File: rtl/sdio_cmd_engine.sv
// -----------------------------------------------------------------------------
// sdio_cmd_engine
//
// CMD-line engine of the SDIO controller. Runs entirely in the divided SDIO
// clock domain and shifts one CMD bit per clock.
//
// On a start pulse the engine:
//   - serialises a 48-bit command frame (start, transmission, index, argument,
//     CRC7, end) onto the CMD line;
//   - releases the line for a two-cycle turnaround;
//   - waits up to RSP_TIMEOUT cycles for a response start bit;
//   - captures a 48-bit or 136-bit response, checks it and reports completion.
//
// Ports
//   clk_i        SDIO clock, one CMD bit per cycle
//   rstn_i       asynchronous active-low reset
//   start_i      single-cycle start pulse (ignored unless idle)
//   op_i         command index
//   arg_i        command argument
//   rsp_type_i   0 none, 1 R1/R6/R7, 2 R3/R4, 3 R2, 4 R1b; other codes = none
//   busy_o       high from the cycle after an accepted start through done_o
//   done_o       single-cycle completion pulse
//   rsp_data_o   captured response (48-bit: index in [37:32], payload in
//                [31:0]; R2: response bits 127..0)
//   status_o     [0] timeout, [1] CRC, [2] end bit, [3] start/transmission bit
//   sdcmd_o      CMD line output value
//   sdcmd_oen_o  CMD output enable, active-low
//   sdcmd_i      CMD line input
//
// All outputs are registered. The output process works on the next-state
// values, so the outputs line up with the state the engine is entering.
// -----------------------------------------------------------------------------
module sdio_cmd_engine #(
  parameter int RSP_TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         start_i,
  input  logic [5:0]   op_i,
  input  logic [31:0]  arg_i,
  input  logic [2:0]   rsp_type_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] rsp_data_o,
  output logic [3:0]   status_o,
  output logic         sdcmd_o,
  output logic         sdcmd_oen_o,
  input  logic         sdcmd_i
);

  // One counter serves every state. It must hold the 136-bit receive length
  // as well as the response timeout.
  localparam int TO_W  = $clog2(RSP_TIMEOUT + 1);
  localparam int CNT_W = (TO_W > 8) ? TO_W : 8;

  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(47);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RSP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RX_LEN48  = CNT_W'(47);
  localparam logic [CNT_W-1:0] RX_LEN136 = CNT_W'(135);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURN,
    S_WAIT,
    S_RX,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_48_CRC,
    RSP_48_NOCRC,
    RSP_136
  } rsp_kind_t;

  // CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first. Leading zero
  // bits leave a zero-initialised CRC unchanged, so shorter fields are simply
  // zero-extended on the left.
  function automatic logic [6:0] crc7(input logic [119:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic rsp_kind_t decode_rsp(input logic [2:0] t);
    case (t)
      3'd1, 3'd4: return RSP_48_CRC;
      3'd2:       return RSP_48_NOCRC;
      3'd3:       return RSP_136;
      default:    return RSP_NONE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and their next values
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rsp_kind_t        kind_q, kind_d;
  logic [47:0]      tx_sh_q, tx_sh_d;
  logic [135:0]     rx_sh_q, rx_sh_d;
  logic [3:0]       status_d;
  logic [127:0]     rsp_data_d;
  logic             busy_d, done_d, sdcmd_d, sdcmd_oen_d;

  // Command frame built from the live inputs; only loaded on an accepted start.
  logic [6:0]       tx_crc;
  logic [47:0]      tx_frame;

  // Receive word including the bit being sampled this cycle.
  logic [135:0]     rx_full;
  logic [119:0]     rx_crc_field;
  logic [6:0]       rx_crc;
  logic             rx_trans_err;

  assign tx_crc   = crc7({80'b0, 2'b01, op_i, arg_i});
  assign tx_frame = {2'b01, op_i, arg_i, tx_crc, 1'b1};

  assign rx_full      = {rx_sh_q[134:0], sdcmd_i};
  assign rx_crc_field = (kind_q == RSP_136) ? rx_full[127:8]
                                            : {80'b0, rx_full[47:8]};
  assign rx_crc       = crc7(rx_crc_field);
  // The start bit is always 0 here (it is what started the capture), so
  // folding it in only ever reflects the transmission bit.
  assign rx_trans_err = (kind_q == RSP_136) ? (rx_full[135] | rx_full[134])
                                            : (rx_full[47]  | rx_full[46]);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      kind_q      <= RSP_NONE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rsp_data_o  <= '0;
      status_o    <= '0;
      sdcmd_o     <= 1'b1;
      sdcmd_oen_o <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      rsp_data_o  <= rsp_data_d;
      status_o    <= status_d;
      sdcmd_o     <= sdcmd_d;
      sdcmd_oen_o <= sdcmd_oen_d;
    end
  end

  // NOTE: the shift registers carry no reset. Each is loaded in full before
  // it is ever observed, so a reset would only add fan-out on rstn_i.
  always_ff @(posedge clk_i) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default at the
  // top; a path that skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    status_d   = status_o;
    rsp_data_d = rsp_data_o;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_TX;
          cnt_d    = '0;
          kind_d   = decode_rsp(rsp_type_i);
          tx_sh_d  = tx_frame;
          status_d = '0;
        end
      end

      // The MSB of tx_sh is the bit on the line; shift after each bit.
      S_TX: begin
        tx_sh_d = {tx_sh_q[46:0], 1'b0};
        if (cnt_q == TX_LAST) begin
          state_d = (kind_q == RSP_NONE) ? S_DONE : S_TURN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Line released; whatever the card drives here is ignored.
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT: begin
        if (!sdcmd_i) begin
          // Start bit seen: capture it as a 0 and count the remaining bits.
          state_d = S_RX;
          rx_sh_d = '0;
          cnt_d   = (kind_q == RSP_136) ? RX_LEN136 : RX_LEN48;
        end else if (cnt_q == WAIT_LAST) begin
          state_d     = S_DONE;
          status_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RX: begin
        rx_sh_d = rx_full;
        if (cnt_q == TURN_LAST) begin
          // Last bit is being sampled now: evaluate on the completed word.
          state_d     = S_DONE;
          status_d[3] = rx_trans_err;
          status_d[2] = ~rx_full[0];
          status_d[1] = (kind_q != RSP_48_NOCRC) && (rx_crc != rx_full[7:1]);
          status_d[0] = 1'b0;
          if (kind_q == RSP_136) begin
            rsp_data_d = rx_full[127:0];
          end else begin
            rsp_data_d = {90'b0, rx_full[45:40], rx_full[39:8]};
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (registered next values, derived from the state being entered)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    sdcmd_oen_d = (state_d != S_TX);
    sdcmd_d     = (state_d == S_TX) ? tx_sh_d[47] : 1'b1;
  end

endmodule

// File: tb/tb_sdio_cmd_engine.sv
// -----------------------------------------------------------------------------
// tb_sdio_cmd_engine
//
// Directed bench for sdio_cmd_engine. A table of command records (inputs,
// card response, expected frame/status/data/done cycle) is applied in a loop;
// reset-in-the-middle-of-a-response is a hand-written sequence.
//
// Cycle numbering follows the engine: cycle 0 is the cycle in which start_i is
// sampled high. Inputs are driven and outputs sampled on the falling edge, so a
// value driven in cycle c is sampled by the DUT at the end of cycle c and the
// registered outputs seen in cycle c were updated at the start of cycle c.
// -----------------------------------------------------------------------------
module tb_sdio_cmd_engine;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [5:0]   op;
  logic [31:0]  arg;
  logic [2:0]   rsp_type;
  logic         busy;
  logic         done;
  logic [127:0] rsp_data;
  logic [3:0]   status;
  logic         sdcmd;
  logic         sdcmd_oen;
  logic         sdcmd_in;

  int n_cmp = 0;
  int n_bad = 0;

  sdio_cmd_engine #(.RSP_TIMEOUT(64)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (start),
    .op_i        (op),
    .arg_i       (arg),
    .rsp_type_i  (rsp_type),
    .busy_o      (busy),
    .done_o      (done),
    .rsp_data_o  (rsp_data),
    .status_o    (status),
    .sdcmd_o     (sdcmd),
    .sdcmd_oen_o (sdcmd_oen),
    .sdcmd_i     (sdcmd_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [5:0]   op;
    logic [31:0]  arg;
    logic [2:0]   rsp_type;
    logic [47:0]  frame;       // expected command frame
    bit           has_rsp;     // card answers
    logic [135:0] rsp;         // response bits, right-aligned
    int           rsp_len;     // 48 or 136
    int           delay;       // start bit appears in cycle 51 + delay
    bit           turn_noise;  // card pulls CMD low during the turnaround
    int           extra_start; // cycle of a second start pulse, 0 = none
    logic [3:0]   exp_status;
    logic [127:0] exp_data;
    int           exp_done;    // cycle in which done_o must be high
  } vec_t;

  task automatic check(input string name, input logic [135:0] act,
                       input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference CRC7 written as the x^7 + x^3 + 1 LFSR, processing the lowest
  // nbits of data MSB first.
  function automatic logic [6:0] crc7_tb(input logic [135:0] data, input int nbits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb   = data[i] ^ c[6];
      c[6] = c[5];
      c[5] = c[4];
      c[4] = c[3];
      c[3] = c[2] ^ fb;
      c[2] = c[1];
      c[1] = c[0];
      c[0] = fb;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk48(input logic [7:0] top, input logic [31:0] body);
    return {top, body, crc7_tb({96'b0, top, body}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk136(input logic [119:0] payload);
    return {2'b00, 6'h3F, payload, crc7_tb({16'b0, payload}, 120), 1'b1};
  endfunction

  // Run one table record from the start pulse to one cycle after done.
  task automatic run_cmd(input vec_t v);
    logic [47:0] got_frame;
    logic        oen_seen_high;
    int          done_cycle;
    int          rs;
    got_frame     = '0;
    oen_seen_high = 1'b0;
    done_cycle    = -1;
    rs            = 51 + v.delay;

    // cycle 0
    @(negedge clk);
    check({v.name, "/oen_idle"}, 136'(sdcmd_oen), 136'(1'b1));
    start    = 1'b1;
    op       = v.op;
    arg      = v.arg;
    rsp_type = v.rsp_type;
    sdcmd_in = 1'b1;

    for (int c = 1; c <= v.exp_done + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.extra_start != 0 && c == v.extra_start) begin
        start = 1'b1;
        op    = 6'h3F;
        arg   = 32'hFFFF_FFFF;
      end
      if (c == 1) check({v.name, "/busy_c1"}, 136'(busy), 136'(1'b1));
      if (c >= 1 && c <= 48) begin
        got_frame     = {got_frame[46:0], sdcmd};
        oen_seen_high = oen_seen_high | sdcmd_oen;
      end
      if (c == 48) begin
        check({v.name, "/frame"}, 136'(got_frame), 136'(v.frame));
        check({v.name, "/oen_tx"}, 136'(oen_seen_high), 136'(1'b0));
      end
      if (c == 49) check({v.name, "/release"}, 136'({sdcmd_oen, sdcmd}), 136'(2'b11));
      if (done && done_cycle < 0) done_cycle = c;
      if (c == v.exp_done) begin
        check({v.name, "/status"}, 136'(status), 136'(v.exp_status));
        check({v.name, "/data"}, 136'(rsp_data), 136'(v.exp_data));
        check({v.name, "/busy_done"}, 136'(busy), 136'(1'b1));
      end
      if (c == v.exp_done + 1) begin
        check({v.name, "/post"}, 136'({busy, done}), 136'(2'b00));
      end
      // Card model drives the line for this cycle.
      if (v.turn_noise && (c == 49 || c == 50)) begin
        sdcmd_in = 1'b0;
      end else if (v.has_rsp && c >= rs && c < rs + v.rsp_len) begin
        sdcmd_in = v.rsp[v.rsp_len - 1 - (c - rs)];
      end else begin
        sdcmd_in = 1'b1;
      end
    end
    check({v.name, "/done_cycle"}, 136'(done_cycle), 136'(v.exp_done));
    sdcmd_in = 1'b1;
  endtask

  vec_t         vecs[9];
  logic [135:0] r2_good;
  logic [47:0]  r7_rsp;

  initial begin
    r2_good = mk136({32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C, 24'h4B5A69});
    r7_rsp  = 48'h08_0000_01AA_13;

    //         name        op     arg            type  frame                          rsp? rsp                         len  dly tn  xs  status    data                            done
    vecs[0] = '{"cmd0",    6'd0,  32'h0,         3'd0, 48'h40_0000_0000_95,           0,   136'h0,                     48,  0,  0,  10, 4'b0000, 128'h0,                         49};
    vecs[1] = '{"cmd8_r7", 6'd8,  32'h1AA,       3'd1, 48'h48_0000_01AA_87,           1,   136'(r7_rsp),               48,  5,  0,  0,  4'b0000, 128'h08_0000_01AA,              56 + 48};
    vecs[2] = '{"crc_err", 6'd8,  32'h1AA,       3'd1, 48'h48_0000_01AA_87,           1,   136'h08_0000_01AA_15,       48,  5,  0,  0,  4'b0010, 128'h08_0000_01AA,              56 + 48};
    vecs[3] = '{"timeout", 6'd8,  32'h1AA,       3'd1, 48'h48_0000_01AA_87,           0,   136'h0,                     48,  0,  1,  0,  4'b0001, 128'h08_0000_01AA,              48 + 2 + 64 + 1};
    vecs[4] = '{"r2_ok",   6'd2,  32'h0,         3'd3, 48'h42_0000_0000_4D,           1,   r2_good,                    136, 2,  0,  0,  4'b0000, r2_good[127:0],                 53 + 136};
    vecs[5] = '{"r2_end",  6'd2,  32'h0,         3'd3, 48'h42_0000_0000_4D,           1,   r2_good ^ 136'h1,           136, 2,  0,  0,  4'b0100, r2_good[127:0] ^ 128'h1,        53 + 136};
    vecs[6] = '{"r3_late", 6'd41, 32'h40FF_8000, 3'd2, mk48(8'h69, 32'h40FF_8000),    1,   136'h3F_80FF_8000_FF,       48,  63, 0,  0,  4'b0000, 128'h3F_80FF_8000,              114 + 48};
    vecs[7] = '{"r1b_tx",  6'd7,  32'h1234_0000, 3'd4, mk48(8'h47, 32'h1234_0000),    1,   136'(mk48(8'h47, 32'h900)), 48,  0,  0,  0,  4'b1000, 128'h07_0000_0900,              51 + 48};
    vecs[8] = '{"type5",   6'd0,  32'h0,         3'd5, 48'h40_0000_0000_95,           0,   136'h0,                     48,  0,  0,  0,  4'b0000, 128'h07_0000_0900,              49};

    rstn     = 1'b0;
    start    = 1'b0;
    op       = '0;
    arg      = '0;
    rsp_type = '0;
    sdcmd_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset/outputs", 136'({busy, done, status, sdcmd, sdcmd_oen}), 136'(8'b0000_0011));
    check("reset/data", 136'(rsp_data), 136'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Reset asserted while the response to CMD8 is being shifted in.
    @(negedge clk);
    start    = 1'b1;
    op       = 6'd8;
    arg      = 32'h1AA;
    rsp_type = 3'd1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      start    = 1'b0;
      sdcmd_in = (c >= 51 && c < 99) ? r7_rsp[47 - (c - 51)] : 1'b1;
    end
    check("rst_rx/busy_pre", 136'(busy), 136'(1'b1));
    rstn = 1'b0;
    #1;
    check("rst_rx/line", 136'({sdcmd_oen, sdcmd}), 136'(2'b11));
    check("rst_rx/busy", 136'({busy, done}), 136'(2'b00));
    check("rst_rx/data", 136'({status, rsp_data}), 136'h0);
    sdcmd_in = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_cmd(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
